// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - DEPTH-entry fetch-to-decode instruction FIFO with flush
module instr_fetch_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ifq_flush_in,
    input  logic [ADDR_WIDTH-1:0]      ifq_instr_addr_in,
    input  logic [INSTR_WIDTH-1:0]     ifq_instr_in,
    input  logic                       ifq_instr_valid_in,
    output logic                       ifq_instr_ready_out,
    output logic [ADDR_WIDTH-1:0]      ifq_instr_addr_out,
    output logic [INSTR_WIDTH-1:0]     ifq_instr_out,
    output logic                       ifq_instr_valid_out,
    input  logic                       ifq_instr_ready_in,
    output logic [$clog2(DEPTH):0]     ifq_count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]  addr_mem  [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   push;
    logic                   pop;

    // Ready looks only at occupancy, so a full queue cannot push in the cycle it pops.
    assign ifq_instr_ready_out = (count != CNT_W'(DEPTH));
    assign ifq_instr_valid_out = (count != '0);
    assign ifq_count_out       = count;

    assign push = ifq_instr_valid_in & ifq_instr_ready_out & ~ifq_flush_in;
    assign pop  = ifq_instr_valid_out & ifq_instr_ready_in & ~ifq_flush_in;

    always_comb begin
        ifq_instr_addr_out = '0;
        ifq_instr_out      = NOP_INSTR;
        if (ifq_instr_valid_out) begin
            ifq_instr_addr_out = addr_mem[rd_ptr];
            ifq_instr_out      = instr_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ifq_flush_in) begin
            // Entries are abandoned in place; only the read pointer catches up.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && rst) begin
            addr_mem[wr_ptr]  <= ifq_instr_addr_in;
            instr_mem[wr_ptr] <= ifq_instr_in;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized and directed bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] addr_in;
    logic [31:0] instr_in;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] addr_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        ready_in;
    logic [2:0]  count_out;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] i;
    } ent_t;

    ent_t q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifq_flush_in(flush),
        .ifq_instr_addr_in(addr_in),
        .ifq_instr_in(instr_in),
        .ifq_instr_valid_in(valid_in),
        .ifq_instr_ready_out(ready_out),
        .ifq_instr_addr_out(addr_out),
        .ifq_instr_out(instr_out),
        .ifq_instr_valid_out(valid_out),
        .ifq_instr_ready_in(ready_in),
        .ifq_count_out(count_out)
    );

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ea;
        logic [31:0] ei;
        ea = (q.size() != 0) ? q[0].a : 32'h0;
        ei = (q.size() != 0) ? q[0].i : NOP;
        cmp({tag, ".valid"}, 64'(valid_out), 64'(q.size() != 0));
        cmp({tag, ".ready"}, 64'(ready_out), 64'(q.size() != DEPTH));
        cmp({tag, ".count"}, 64'(count_out), 64'(q.size()));
        cmp({tag, ".addr"},  64'(addr_out),  64'(ea));
        cmp({tag, ".instr"}, 64'(instr_out), 64'(ei));
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, ".valid"}, 64'(valid_out), 64'(0));
        cmp({tag, ".ready"}, 64'(ready_out), 64'(1));
        cmp({tag, ".count"}, 64'(count_out), 64'(0));
        cmp({tag, ".addr"},  64'(addr_out),  64'(0));
        cmp({tag, ".instr"}, 64'(instr_out), 64'(NOP));
    endtask

    // Drive one cycle's inputs, advance the reference queue at the edge, check at negedge.
    task automatic cycle(input string tag, input logic f, input logic v,
                         input logic [31:0] a, input logic [31:0] ins, input logic r);
        bit do_push;
        bit do_pop;
        flush = f; valid_in = v; addr_in = a; instr_in = ins; ready_in = r;
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else if (f) begin
            q.delete();
        end else begin
            do_push = v && (q.size() != DEPTH);
            do_pop  = r && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{a: a, i: ins});
        end
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        addr_in = '0; instr_in = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // Fill while decode stalls; fifth instruction waits at the input.
        for (int k = 0; k < 4; k++) begin
            cycle("fill", 1'b0, 1'b1, 32'(k * 4), 32'hA000_0000 + 32'(k), 1'b0);
            cmp("fill.count_const", 64'(count_out), 64'(k + 1));
        end
        cmp("full.ready_low", 64'(ready_out), 64'(0));
        cycle("full_hold", 1'b0, 1'b1, 32'h10, 32'hA000_0004, 1'b0);
        cycle("full_hold", 1'b0, 1'b1, 32'h10, 32'hA000_0004, 1'b0);
        cmp("full.head", 64'(addr_out), 64'(0));
        cmp("full.count4", 64'(count_out), 64'(4));
        cycle("full_pop", 1'b0, 1'b1, 32'h10, 32'hA000_0004, 1'b1);
        cmp("full_pop.count3", 64'(count_out), 64'(3));
        cycle("after_pop", 1'b0, 1'b1, 32'h10, 32'hA000_0004, 1'b1);
        cmp("after_pop.count3", 64'(count_out), 64'(3));
        for (int k = 0; k < 4; k++) cycle("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cmp("drain.empty", 64'(count_out), 64'(0));

        // Streaming with both sides open: one-cycle lead, then count holds at 1.
        for (int k = 0; k < 10; k++) begin
            cycle("stream", 1'b0, 1'b1, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1);
            cmp("stream.count1", 64'(count_out), 64'(1));
            cmp("stream.addr", 64'(addr_out), 64'(32'h100 + 32'(4 * k)));
        end
        cycle("stream_end", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Flush with three held entries and a push attempt in the flush cycle.
        for (int k = 0; k < 3; k++) cycle("pre_flush", 1'b0, 1'b1, 32'h180 + 32'(4 * k), 32'hC0 + 32'(k), 1'b0);
        cycle("flush", 1'b1, 1'b1, 32'h1FC, 32'hDEAD_BEEF, 1'b0);
        cmp("flush.count0", 64'(count_out), 64'(0));
        cmp("flush.nop", 64'(instr_out), 64'(NOP));
        cycle("post_flush", 1'b0, 1'b1, 32'h200, 32'hCAFE_0200, 1'b0);
        cmp("post_flush.addr", 64'(addr_out), 64'(32'h200));
        cycle("post_flush2", 1'b0, 1'b1, 32'h204, 32'hCAFE_0204, 1'b0);

        // Asynchronous reset between edges while two entries are held.
        cmp("pre_areset.count2", 64'(count_out), 64'(2));
        #2 rst = 1'b0;
        #1 check_reset_vals("areset_now");
        q.delete();
        cycle("in_areset", 1'b0, 1'b1, 32'h300, 32'h300, 1'b0);
        check_reset_vals("in_areset_const");
        rst = 1'b1;
        #1 check_reset_vals("areset_release");
        cycle("first_push", 1'b0, 1'b1, 32'h400, 32'h0400_0013, 1'b0);
        cmp("first_push.addr", 64'(addr_out), 64'(32'h400));
        cycle("drain2", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Random traffic against the reference queue.
        for (int k = 0; k < 400; k++) begin
            cycle("rand", ($urandom_range(15) == 0), ($urandom_range(3) != 0),
                  $urandom, $urandom, ($urandom_range(2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction buffer between fetch and decode. It generalises the single-stage fetch delay register into a DEPTH-entry FIFO with valid/ready handshakes on both sides, so fetch keeps running while decode stalls. A jump/flush discards every buffered entry. When the queue is empty, decode sees a NOP with valid low.

## Interface
Parameters:
- ADDR_WIDTH, 32, instruction address width
- INSTR_WIDTH, 32, instruction word width
- DEPTH, 4, number of entries; power of two, ≥2
- NOP_INSTR, 32'h00000013, instruction presented when no valid entry (INSTR_WIDTH bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- ifq_flush_in  in  1  jump/flush request from execute
- ifq_instr_addr_in  in  ADDR_WIDTH  fetched instruction address
- ifq_instr_in  in  INSTR_WIDTH  fetched instruction word
- ifq_instr_valid_in  in  1  fetch presents a valid instruction
- ifq_instr_ready_out  out  1  queue accepts a push this cycle
- ifq_instr_addr_out  out  ADDR_WIDTH  head entry address
- ifq_instr_out  out  INSTR_WIDTH  head entry instruction
- ifq_instr_valid_out  out  1  head entry valid
- ifq_instr_ready_in  in  1  decode accepts the head this cycle
- ifq_count_out  out  $clog2(DEPTH)+1  number of stored entries

## Operation
- Storage: DEPTH-entry array of {addr, instr}. Write pointer wr_ptr and read pointer rd_ptr are each $clog2(DEPTH) bits, plus a count register of $clog2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH by natural overflow.
- push = ifq_instr_valid_in & ifq_instr_ready_out & ~ifq_flush_in.
- pop = ifq_instr_valid_out & ifq_instr_ready_in & ~ifq_flush_in.
- ifq_instr_ready_out = (count != DEPTH). It depends on count only, never on ifq_instr_ready_in, so there is no combinational ready path.
- Outputs are driven combinationally from the head entry (mem[rd_ptr]) and count:
  - ifq_instr_valid_out = (count != 0)
  - when count == 0: addr_out = 0 and instr_out = NOP_INSTR
- Count update: push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance.
- Flush has priority over everything. On a flush cycle:
  - next count = 0 and rd_ptr = wr_ptr
  - any push or pop in the same cycle is discarded
  - storage contents are not cleared
- Full with pop: ready_out stays low in that cycle (no push-on-pop when full); the freed slot accepts a push from the next cycle.
- Empty: no bypass. A pushed instruction appears at the outputs one cycle after acceptance.
- Reset (rst = 0, asynchronous, including mid-operation):
  - count = 0, wr_ptr = 0, rd_ptr = 0
  - outputs: valid_out = 0, addr_out = 0, instr_out = NOP_INSTR, ready_out = 1, count_out = 0
  - pushes are ignored while rst is low
  - the storage array needs no reset

## Timing
- Push-to-output latency: 1 cycle when the queue is empty. Otherwise the entry reaches the head after all older entries are popped.
- Throughput: 1 push and 1 pop per cycle, sustained when 0 < count < DEPTH.
- Flush asserted in cycle N: from cycle N+1 valid_out = 0, instr_out = NOP_INSTR, count_out = 0 and ready_out = 1. The first post-flush push is accepted in cycle N+1.
- Reset release: the first push is accepted on the first rising edge where rst = 1.
- count_out, valid_out and ready_out all derive from the same count register, so they are mutually consistent in every cycle.

## Test plan
- Reset, then idle: after rst deassert → valid_out = 0, instr_out = 32'h00000013, addr_out = 0, ready_out = 1, count_out = 0.
- Fill while decode stalled (ready_in = 0, DEPTH = 4):
  - push addrs 0x00, 0x04, 0x08, 0x0C → count_out 1, 2, 3, 4, then ready_out = 0
  - 5th instruction held on the input is not accepted until one pop
  - head stays addr 0x00
- Streaming: valid_in = 1 and ready_in = 1 every cycle for 10 instructions (addrs 0x100 upward by 4) → outputs 0x100.. in order, one per cycle after a 1-cycle lead, count_out = 1 steady, pointers wrap cleanly past DEPTH.
- Flush while holding 3 entries with valid_in = 1 in the flush cycle → next cycle count_out = 0, valid_out = 0, instr_out = NOP; the flush-cycle instruction is dropped; the next push (addr 0x200) appears one cycle later.
- Full with simultaneous pop: count = 4, ready_in = 1, valid_in = 1 → that cycle pops only, count_out = 3; the following cycle the push is accepted and count_out stays 3 (with ready_in = 1).
- Asynchronous reset mid-stream: rst driven low between clock edges with count = 2 → outputs go to reset values immediately, without waiting for clk; after release the queue is empty and the old entries never reappear.
